instr_aligner: RTL and testbench

Instruction realignment controller between the fetch interface and the decode stage. It consumes 32-bit, word-aligned fetch words and emits one instruction per handshake: either a 16-bit RVC instruction, zero-extended, for the compressed decoder, or a full 32-bit instruction, including ones that straddle two fetch words. It holds a one-halfword carry buffer, sequences consumption of fetch words, and restarts on flush at either halfword of a word.

---
 rtl/instr_aligner.sv | 159 +++++++++++++++
 tb/tb_instr_aligner.sv | 130 +++++++++++++
 2 files changed

// File: rtl/instr_aligner.sv
// RV32C instruction realigner: turns word-aligned fetch words into one 16- or 32-bit
// instruction per decode handshake, carrying a halfword across fetch-word boundaries.
module instr_aligner (
   input  logic        s_clk_i,
   input  logic        s_rst_i,
   input  logic        s_flush_i,
   input  logic        s_flush_hw_i,
   input  logic        s_fetch_val_i,
   input  logic [31:0] s_fetch_data_i,
   input  logic        s_fetch_err_i,
   output logic        s_fetch_rdy_o,
   output logic        s_instr_val_o,
   input  logic        s_instr_rdy_i,
   output logic [31:0] s_instr_o,
   output logic        s_rvc_o,
   output logic        s_err_o
);

   typedef enum logic [1:0] {StAligned, StSkip, StHalf} state_e;

   state_e      state_q, state_d;
   logic [15:0] hbuf_q, hbuf_d;
   logic        herr_q, herr_d;

   logic [15:0] lo_hw, hi_hw;
   logic        lo_rvc, hi_rvc, hbuf_rvc;
   logic        instr_val, fetch_rdy, out_hs;
   logic [31:0] instr;
   logic        rvc, err;

   assign lo_hw    = s_fetch_data_i[15:0];
   assign hi_hw    = s_fetch_data_i[31:16];
   assign lo_rvc   = (lo_hw[1:0] != 2'b11);
   assign hi_rvc   = (hi_hw[1:0] != 2'b11);
   assign hbuf_rvc = (hbuf_q[1:0] != 2'b11);

   // Output selection: what decode sees in the current cycle.
   always_comb begin
      instr_val = 1'b0;
      instr     = 32'h0;
      rvc       = 1'b0;
      err       = 1'b0;
      unique case (state_q)
         StAligned: begin
            instr_val = s_fetch_val_i;
            err       = s_fetch_err_i;
            if (lo_rvc) begin
               instr = {16'h0, lo_hw};
               rvc   = 1'b1;
            end else begin
               instr = s_fetch_data_i;
            end
         end
         StSkip: begin
            if (hi_rvc) begin
               instr_val = s_fetch_val_i;
               instr     = {16'h0, hi_hw};
               rvc       = 1'b1;
               err       = s_fetch_err_i;
            end
         end
         StHalf: begin
            if (hbuf_rvc) begin
               instr_val = 1'b1;
               instr     = {16'h0, hbuf_q};
               rvc       = 1'b1;
               err       = herr_q;
            end else begin
               instr_val = s_fetch_val_i;
               instr     = {lo_hw, hbuf_q};
               err       = herr_q | s_fetch_err_i;
            end
         end
         default: ;
      endcase
      if (s_flush_i) begin
         instr_val = 1'b0;
      end
      // Payload is zero whenever nothing is offered.
      if (!instr_val) begin
         instr = 32'h0;
         rvc   = 1'b0;
         err   = 1'b0;
      end
   end

   assign out_hs = instr_val & s_instr_rdy_i;

   // Consumption and next-state sequencing.
   always_comb begin
      state_d   = state_q;
      hbuf_d    = hbuf_q;
      herr_d    = herr_q;
      fetch_rdy = 1'b0;
      unique case (state_q)
         StAligned: begin
            if (out_hs) begin
               fetch_rdy = 1'b1;
               if (lo_rvc) begin
                  hbuf_d  = hi_hw;
                  herr_d  = s_fetch_err_i;
                  state_d = StHalf;
               end
            end
         end
         StSkip: begin
            if (hi_rvc) begin
               if (out_hs) begin
                  fetch_rdy = 1'b1;
                  state_d   = StAligned;
               end
            end else if (s_fetch_val_i) begin
               // Upper half starts a 32-bit instruction: swallow the word, no output.
               fetch_rdy = 1'b1;
               hbuf_d    = hi_hw;
               herr_d    = s_fetch_err_i;
               state_d   = StHalf;
            end
         end
         StHalf: begin
            if (out_hs) begin
               if (hbuf_rvc) begin
                  state_d = StAligned;
               end else begin
                  fetch_rdy = 1'b1;
                  hbuf_d    = hi_hw;
                  herr_d    = s_fetch_err_i;
               end
            end
         end
         default: state_d = StAligned;
      endcase
      if (s_flush_i) begin
         fetch_rdy = 1'b0;
         hbuf_d    = 16'h0;
         herr_d    = 1'b0;
         state_d   = s_flush_hw_i ? StSkip : StAligned;
      end
   end

   always_ff @(posedge s_clk_i) begin
      if (s_rst_i) begin
         state_q <= StAligned;
         hbuf_q  <= 16'h0;
         herr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hbuf_q  <= hbuf_d;
         herr_q  <= herr_d;
      end
   end

   assign s_fetch_rdy_o = fetch_rdy;
   assign s_instr_val_o = instr_val;
   assign s_instr_o     = instr;
   assign s_rvc_o       = rvc;
   assign s_err_o       = err;

endmodule

// File: tb/tb_instr_aligner.sv
// Cycle-level bench for instr_aligner: each stimulus vector pushes its hand-derived
// expected outputs to a scoreboard queue, popped and compared on the falling edge.
module tb_instr_aligner;

   logic        clk = 1'b0;
   logic        rst, flush, flush_hw, fetch_val, fetch_err, fetch_rdy;
   logic        instr_val, instr_rdy, rvc, err;
   logic [31:0] fetch_data, instr;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       tag;
      logic        val;
      logic [31:0] instr;
      logic        rvc;
      logic        err;
      logic        frdy;
      logic        zchk;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   instr_aligner dut (
      .s_clk_i        (clk),
      .s_rst_i        (rst),
      .s_flush_i      (flush),
      .s_flush_hw_i   (flush_hw),
      .s_fetch_val_i  (fetch_val),
      .s_fetch_data_i (fetch_data),
      .s_fetch_err_i  (fetch_err),
      .s_fetch_rdy_o  (fetch_rdy),
      .s_instr_val_o  (instr_val),
      .s_instr_rdy_i  (instr_rdy),
      .s_instr_o      (instr),
      .s_rvc_o        (rvc),
      .s_err_o        (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs after the rising edge and queue what decode must see.
   task automatic step(input string tag, input bit r, input bit fl, input bit fhw,
                       input bit fv, input logic [31:0] d, input bit fe, input bit ir,
                       input bit ev, input logic [31:0] ei, input bit er, input bit ee,
                       input bit efr, input bit z);
      exp_t e;
      @(posedge clk);
      #1;
      rst        = r;
      flush      = fl;
      flush_hw   = fhw;
      fetch_val  = fv;
      fetch_data = d;
      fetch_err  = fe;
      instr_rdy  = ir;
      e.tag = tag; e.val = ev; e.instr = ei; e.rvc = er; e.err = ee; e.frdy = efr; e.zchk = z;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check({e.tag, ".val"}, {31'h0, instr_val}, {31'h0, e.val});
         check({e.tag, ".frdy"}, {31'h0, fetch_rdy}, {31'h0, e.frdy});
         if (e.val || e.zchk) begin
            check({e.tag, ".instr"}, instr, e.instr);
            check({e.tag, ".rvc"}, {31'h0, rvc}, {31'h0, e.rvc});
            check({e.tag, ".err"}, {31'h0, err}, {31'h0, e.err});
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; flush_hw = 1'b0; fetch_val = 1'b0;
      fetch_data = 32'h0; fetch_err = 1'b0; instr_rdy = 1'b1;
      //   tag        rst fl fhw fv data          fe rdy | val instr       rvc err frdy z
      step("rst0",    1, 0, 0, 0, 32'h00000000, 0, 1,    0, 32'h00000000, 0, 0, 0, 1);
      step("rst1",    1, 0, 0, 0, 32'h00000000, 0, 1,    0, 32'h00000000, 0, 0, 0, 1);
      step("idle",    0, 0, 0, 0, 32'h00000000, 0, 1,    0, 32'h00000000, 0, 0, 0, 1);
      step("w32a",    0, 0, 0, 1, 32'h00000013, 0, 1,    1, 32'h00000013, 0, 0, 1, 0);
      step("w32b",    0, 0, 0, 1, 32'h00B50533, 0, 1,    1, 32'h00B50533, 0, 0, 1, 0);
      step("cli_lo",  0, 0, 0, 1, 32'h45014501, 0, 1,    1, 32'h00004501, 1, 0, 1, 0);
      step("cli_hi",  0, 0, 0, 1, 32'h05134501, 0, 1,    1, 32'h00004501, 1, 0, 0, 0);
      step("c_lo",    0, 0, 0, 1, 32'h05134501, 0, 1,    1, 32'h00004501, 1, 0, 1, 0);
      step("strad",   0, 0, 0, 1, 32'h00000000, 0, 1,    1, 32'h00000513, 0, 0, 1, 0);
      step("hbuf0",   0, 0, 0, 0, 32'h00000000, 0, 1,    1, 32'h00000000, 1, 0, 0, 0);
      step("fl_skip", 0, 1, 1, 1, 32'h12345678, 0, 1,    0, 32'h00000000, 0, 0, 0, 0);
      step("skip32",  0, 0, 0, 1, 32'h00134501, 0, 1,    0, 32'h00000000, 0, 0, 1, 0);
      step("skipout", 0, 0, 0, 1, 32'hAAAA0000, 0, 1,    1, 32'h00000013, 0, 0, 1, 0);
      step("hbufA",   0, 0, 0, 0, 32'h00000000, 0, 1,    1, 32'h0000AAAA, 1, 0, 0, 0);
      step("e_lo",    0, 0, 0, 1, 32'h00B74501, 0, 1,    1, 32'h00004501, 1, 0, 1, 0);
      step("e_strad", 0, 0, 0, 1, 32'h12340513, 1, 1,    1, 32'h051300B7, 0, 1, 1, 0);
      step("e_st0",   0, 0, 0, 1, 32'h00000013, 0, 0,    1, 32'h00001234, 1, 1, 0, 0);
      step("e_st1",   0, 0, 0, 1, 32'h00000013, 0, 0,    1, 32'h00001234, 1, 1, 0, 0);
      step("e_st2",   0, 0, 0, 1, 32'h00000013, 0, 0,    1, 32'h00001234, 1, 1, 0, 0);
      step("e_go",    0, 0, 0, 1, 32'h00000013, 0, 1,    1, 32'h00001234, 1, 1, 0, 0);
      step("a_st0",   0, 0, 0, 1, 32'h00000013, 0, 0,    1, 32'h00000013, 0, 0, 0, 0);
      step("a_st1",   0, 0, 0, 1, 32'h00000013, 0, 0,    1, 32'h00000013, 0, 0, 0, 0);
      step("a_st2",   0, 0, 0, 1, 32'h00000013, 0, 0,    1, 32'h00000013, 0, 0, 0, 0);
      step("a_go",    0, 0, 0, 1, 32'h00000013, 0, 1,    1, 32'h00000013, 0, 0, 1, 0);
      step("h_fill",  0, 0, 0, 1, 32'h00134501, 0, 1,    1, 32'h00004501, 1, 0, 1, 0);
      step("h_flush", 0, 1, 0, 1, 32'hAAAA0000, 0, 1,    0, 32'h00000000, 0, 0, 0, 0);
      step("h_after", 0, 0, 0, 1, 32'h00B50533, 0, 1,    1, 32'h00B50533, 0, 0, 1, 0);
      step("fl_skp2", 0, 1, 1, 1, 32'h45010513, 1, 1,    0, 32'h00000000, 0, 0, 0, 0);
      step("skip16",  0, 0, 0, 1, 32'h45010513, 1, 1,    1, 32'h00004501, 1, 1, 1, 0);
      step("al_idle", 0, 0, 0, 0, 32'h00000000, 0, 1,    0, 32'h00000000, 0, 0, 0, 1);
      step("r_fill",  0, 0, 0, 1, 32'h00134501, 0, 1,    1, 32'h00004501, 1, 0, 1, 0);
      step("r_mid",   1, 0, 0, 0, 32'h00000000, 0, 1,    0, 32'h00000000, 0, 0, 0, 0);
      step("r_after", 0, 0, 0, 1, 32'h00000013, 0, 1,    1, 32'h00000013, 0, 0, 1, 0);
      step("rf_both", 1, 1, 1, 0, 32'h00000000, 0, 1,    0, 32'h00000000, 0, 0, 0, 0);
      step("rf_aft",  0, 0, 0, 1, 32'h00B50533, 0, 1,    1, 32'h00B50533, 0, 0, 1, 0);
      @(negedge clk);
      #1;
      check("sb_drain", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
